// File: rtl/incdec_arbiter.sv
// Purpose: NREQ counters sharing one inc/dec unit, granted round-robin, with priority direct loads.
// Latency: a step granted in cycle N updates its counter at that edge; done_* report it in cycle N+1.
// Backpressure: req_ready is a one-hot grant; it is zero while paused, and the loaded requester is skipped.
module incdec_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int SAT  = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ-1:0]           req_up,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      load_valid,
    input  logic [$clog2(NREQ)-1:0]   load_idx,
    input  logic [W-1:0]              load_val,
    input  logic                      pause,
    output logic [NREQ*W-1:0]         cnt_flat,
    output logic                      done_valid,
    output logic [$clog2(NREQ)-1:0]   done_id,
    output logic [W-1:0]              done_val,
    output logic                      sat_hit
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [W-1:0]    cnt_q [NREQ];
    logic [W-1:0]    cnt_d [NREQ];
    logic [IW-1:0]   done_id_q, done_id_d;
    logic [W-1:0]    done_val_q, done_val_d;
    logic            sat_hit_q, sat_hit_d;

    logic [NREQ-1:0] elig;
    logic            found;
    logic [IW-1:0]   gidx;
    logic            grant;
    logic [W-1:0]    cur;
    logic [W-1:0]    nxt;
    logic            up;
    logic            clamp;

    // Round-robin search from rr_ptr over requesters not blocked by a same-cycle load.
    always_comb begin
        int            j;
        logic [IW-1:0] jj;
        elig  = '0;
        found = 1'b0;
        gidx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req_valid[i] && !(load_valid && (load_idx == IW'(i)));
        end
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_ptr_q) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            jj = IW'(j);
            if (!found && elig[jj]) begin
                found = 1'b1;
                gidx  = jj;
            end
        end
    end

    // Control state and grant: pause wins over any eligible request; reset suppresses grants.
    always_comb begin
        state_d   = IDLE;
        grant     = 1'b0;
        req_ready = '0;
        if (pause) begin
            state_d = HOLD;
        end else if (found) begin
            state_d = GRANT;
        end
        if (!rst && (state_d == GRANT)) begin
            grant           = 1'b1;
            req_ready[gidx] = 1'b1;
        end
    end

    // Shared inc/dec unit: wraps modulo 2^W, or clamps at the rails when SAT is set.
    always_comb begin
        cur   = cnt_q[gidx];
        up    = req_up[gidx];
        clamp = (SAT != 0) && (up ? (&cur) : (cur == '0));
        if (clamp) begin
            nxt = cur;
        end else if (up) begin
            nxt = cur + W'(1);
        end else begin
            nxt = cur - W'(1);
        end
    end

    // Next-state for counters, pointer and completion report; a load never targets the granted counter.
    always_comb begin
        cnt_d      = cnt_q;
        rr_ptr_d   = rr_ptr_q;
        done_id_d  = done_id_q;
        done_val_d = done_val_q;
        sat_hit_d  = 1'b0;
        if (load_valid) begin
            cnt_d[load_idx] = load_val;
        end
        if (grant) begin
            cnt_d[gidx] = nxt;
            rr_ptr_d    = (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
            done_id_d   = gidx;
            done_val_d  = nxt;
            sat_hit_d   = clamp;
        end
    end

    // State registers with synchronous reset that also discards any same-cycle grant or load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            done_id_q  <= '0;
            done_val_q <= '0;
            sat_hit_q  <= 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            done_id_q  <= done_id_d;
            done_val_q <= done_val_d;
            sat_hit_q  <= sat_hit_d;
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // A registered GRANT state is exactly the cycle after a step, so it doubles as the done pulse.
    assign done_valid = (state_q == GRANT);
    assign done_id    = done_id_q;
    assign done_val   = done_val_q;
    assign sat_hit    = sat_hit_q;

    for (genvar g = 0; g < NREQ; g++) begin : g_flat
        assign cnt_flat[g*W +: W] = cnt_q[g];
    end
endmodule

// File: tb/tb_incdec_arbiter.sv
// Purpose: drives a wrapping and a saturating instance with identical directed vectors and scoreboards both.
// Latency: expected completions are queued when a grant is issued and popped when done_valid appears.
// Backpressure: req_ready is compared each cycle against the hand-computed one-hot grant.
module tb_incdec_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_up;
    logic        load_valid, pause;
    logic [1:0]  load_idx;
    logic [7:0]  load_val;

    logic [3:0]  rdy0, rdy1;
    logic [31:0] cnt0, cnt1;
    logic        dv0, dv1, sh0, sh1;
    logic [1:0]  did0, did1;
    logic [7:0]  dval0, dval1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] val;
        logic       sat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    incdec_arbiter #(.NREQ(4), .W(8), .SAT(0)) u_wrap (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_up(req_up), .req_ready(rdy0),
        .load_valid(load_valid), .load_idx(load_idx), .load_val(load_val), .pause(pause),
        .cnt_flat(cnt0), .done_valid(dv0), .done_id(did0), .done_val(dval0), .sat_hit(sh0)
    );

    incdec_arbiter #(.NREQ(4), .W(8), .SAT(1)) u_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_up(req_up), .req_ready(rdy1),
        .load_valid(load_valid), .load_idx(load_idx), .load_val(load_val), .pause(pause),
        .cnt_flat(cnt1), .done_valid(dv1), .done_id(did1), .done_val(dval1), .sat_hit(sh1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation of its instance.
    task automatic mon(input int d, input logic dv, input logic [1:0] id, input logic [7:0] val, input logic sh);
        exp_t e;
        if (dv) begin
            checks++;
            if ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
                errors++;
                $display("FAIL done_unexpected dut%0d: got id %0d val %h with nothing expected", d, id, val);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                if (id !== e.id || val !== e.val || sh !== e.sat) begin
                    errors++;
                    $display("FAIL done dut%0d: got id %0d val %h sat %b expected id %0d val %h sat %b",
                             d, id, val, sh, e.id, e.val, e.sat);
                end
            end
        end else if (sh !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL sat_idle dut%0d: got sat_hit %b without done_valid expected 0", d, sh);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            mon(0, dv0, did0, dval0, sh0);
            mon(1, dv1, did1, dval1, sh1);
        end
    end

    // One cycle of stimulus; gid < 0 means no grant is expected this cycle.
    task automatic cyc(input logic [3:0] v, input logic [3:0] up, input logic lv, input logic [1:0] li,
                       input logic [7:0] lval, input logic p, input int gid,
                       input logic [7:0] e0, input logic s0, input logic [7:0] e1, input logic s1);
        logic [3:0] exp_rdy;
        exp_t       e;
        req_valid  = v;
        req_up     = up;
        load_valid = lv;
        load_idx   = li;
        load_val   = lval;
        pause      = p;
        exp_rdy    = (gid < 0) ? 4'b0000 : (4'b0001 << gid);
        if (gid >= 0) begin
            e = '{id: gid[1:0], val: e0, sat: s0};
            q0.push_back(e);
            e = '{id: gid[1:0], val: e1, sat: s1};
            q1.push_back(e);
        end
        @(negedge clk);
        chk("req_ready_wrap", {28'd0, rdy0}, {28'd0, exp_rdy});
        chk("req_ready_sat", {28'd0, rdy1}, {28'd0, exp_rdy});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 4'b1111;
        req_up = 4'b1111;
        load_valid = 1'b1;
        load_idx = 2'd1;
        load_val = 8'hAA;
        pause = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        // Reset state, with requests and a load pending that must be ignored.
        chk("rst_cnt_wrap", cnt0, 32'h0);
        chk("rst_cnt_sat", cnt1, 32'h0);
        chk("rst_ready", {28'd0, rdy0 | rdy1}, 32'h0);
        chk("rst_done_valid", {30'd0, dv0, dv1}, 32'h0);
        chk("rst_sat_hit", {30'd0, sh0, sh1}, 32'h0);
        chk("rst_done_id_val", {12'd0, did0, did1, dval0, dval1}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Round-robin fairness from requester 0, all incrementing.
        for (int i = 0; i < 8; i++) begin
            cyc(4'b1111, 4'b1111, 1'b0, 2'd0, 8'h00, 1'b0, i % 4,
                (i < 4) ? 8'h01 : 8'h02, 1'b0, (i < 4) ? 8'h01 : 8'h02, 1'b0);
        end
        cyc(4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, -1, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("rr_counters_wrap", cnt0, 32'h02020202);
        chk("rr_counters_sat", cnt1, 32'h02020202);

        // Top rail on counter 1: wraps to 00 vs. clamps at FF.
        cyc(4'b0000, 4'b0000, 1'b1, 2'd1, 8'hFF, 1'b0, -1, 8'h00, 1'b0, 8'h00, 1'b0);
        cyc(4'b0010, 4'b0010, 1'b0, 2'd0, 8'h00, 1'b0, 1, 8'h00, 1'b0, 8'hFF, 1'b1);
        // Bottom rail on counter 1: wraps to FF vs. clamps at 00.
        cyc(4'b0000, 4'b0000, 1'b1, 2'd1, 8'h00, 1'b0, -1, 8'h00, 1'b0, 8'h00, 1'b0);
        cyc(4'b0010, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 1, 8'hFF, 1'b0, 8'h00, 1'b1);

        // rr_ptr is 2: a load on counter 2 blocks requester 2 for that cycle only.
        cyc(4'b0100, 4'b0100, 1'b1, 2'd2, 8'h55, 1'b0, -1, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("load_cnt2_wrap", {24'd0, cnt0[23:16]}, 32'h55);
        chk("load_cnt2_sat", {24'd0, cnt1[23:16]}, 32'h55);
        cyc(4'b0100, 4'b0100, 1'b0, 2'd0, 8'h00, 1'b0, 2, 8'h56, 1'b0, 8'h56, 1'b0);

        // Pause for three cycles (rr_ptr is 3); a load during pause still lands.
        cyc(4'b1111, 4'b1111, 1'b0, 2'd0, 8'h00, 1'b1, -1, 8'h00, 1'b0, 8'h00, 1'b0);
        cyc(4'b1111, 4'b1111, 1'b1, 2'd0, 8'h10, 1'b1, -1, 8'h00, 1'b0, 8'h00, 1'b0);
        cyc(4'b1111, 4'b1111, 1'b0, 2'd0, 8'h00, 1'b1, -1, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("hold_load_cnt0", {24'd0, cnt0[7:0]}, 32'h10);
        // Resumes at the held pointer: requester 3 goes 02 -> 03.
        cyc(4'b1111, 4'b1111, 1'b0, 2'd0, 8'h00, 1'b0, 3, 8'h03, 1'b0, 8'h03, 1'b0);

        // Requester 3 alone, back-to-back decrements, then one step below zero.
        cyc(4'b1000, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 3, 8'h02, 1'b0, 8'h02, 1'b0);
        cyc(4'b1000, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 3, 8'h01, 1'b0, 8'h01, 1'b0);
        cyc(4'b1000, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 3, 8'h00, 1'b0, 8'h00, 1'b0);
        cyc(4'b1000, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 3, 8'hFF, 1'b0, 8'h00, 1'b1);

        // Drain and check held outputs and final counter images.
        cyc(4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, -1, 8'h00, 1'b0, 8'h00, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, -1, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("hold_done_wrap", {22'd0, did0, dval0}, {22'd0, 2'd3, 8'hFF});
        chk("hold_done_sat", {22'd0, did1, dval1}, {22'd0, 2'd3, 8'h00});
        chk("final_cnt_wrap", cnt0, 32'hFF56FF10);
        chk("final_cnt_sat", cnt1, 32'h00560010);
        chk("queue_drained_wrap", q0.size(), 32'd0);
        chk("queue_drained_sat", q1.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/incdec_arbiter.md
INCDEC_ARBITER -- requirements
Module: incdec_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters and counters (2..8).
REQ-002 Parameter W, default 8, counter width in bits.
REQ-003 Parameter SAT, default 0; 0 = modulo-2^W wrap, 1 = saturate at 0 and 2^W-1.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 req_valid  input  NREQ  requester i wants one step on counter i.
REQ-007 req_up  input  NREQ  direction per requester: 1 = increment, 0 = decrement.
REQ-008 req_ready  output  NREQ  one-hot grant; the request is consumed in the cycle where req_valid[i] and req_ready[i] are both high.
REQ-009 load_valid  input  1  direct write of counter load_idx.
REQ-010 load_idx  input  $clog2(NREQ)  counter selected for the load.
REQ-011 load_val  input  W  value to load.
REQ-012 pause  input  1  high: no grants are issued.
REQ-013 cnt_flat  output  NREQ*W  counter i on bits [i*W +: W].
REQ-014 done_valid  output  1  one-cycle pulse; a step completed.
REQ-015 done_id  output  $clog2(NREQ)  requester whose step completed.
REQ-016 done_val  output  W  counter value after that step.
REQ-017 sat_hit  output  1  one-cycle pulse; the completed step was clamped (SAT=1 only).

Function
REQ-018 The block SHALL own NREQ counters and one shared inc/dec unit, and SHALL perform at most one step per cycle.
REQ-019 Arbitration SHALL be round-robin: search starts at rr_ptr and the first valid, non-blocked requester wins.
REQ-020 After a grant to requester g, rr_ptr SHALL become (g+1) mod NREQ; with no grant, rr_ptr SHALL hold.
REQ-021 req_ready SHALL be combinational from req_valid, rr_ptr, pause, load_valid and load_idx, and SHALL be all-zero when pause=1.
REQ-022 Load SHALL take priority: if load_valid=1, requester load_idx is blocked that cycle and counter load_idx takes load_val at the edge; other requesters stay eligible.
REQ-023 Grant in cycle N SHALL write counter g at the edge ending cycle N: +1 if req_up[g], else -1.
REQ-024 Wrap (SAT=0): 2^W-1 +1 -> 0, and 0 -1 -> 2^W-1.
REQ-025 Saturate (SAT=1): 2^W-1 +1 stays 2^W-1, and 0 -1 stays 0; sat_hit SHALL pulse with the matching done_valid.
REQ-026 done_valid, done_id, done_val and sat_hit SHALL be registered, valid in cycle N+1 (latency 1); done_val SHALL equal the counter's new value.
REQ-027 A requester granted in cycle N MAY request again in cycle N+1; its step SHALL operate on the updated value, with no lost or duplicated steps.
REQ-028 Control states SHALL be: IDLE (no eligible request), GRANT (a grant is issued this cycle), HOLD (pause=1).
- Transitions are evaluated every cycle.
- HOLD SHALL take precedence over GRANT.
- Loads SHALL still apply in HOLD.
REQ-029 done_id and done_val SHALL hold their last values when done_valid=0.

Reset
REQ-030 While rst=1 at an edge, all counters, rr_ptr, done_id and done_val SHALL be 0, and done_valid, sat_hit and req_ready SHALL be 0.
REQ-031 A reset asserted in the same cycle as a grant or load SHALL discard that operation; no done pulse SHALL follow.
REQ-032 After rst falls, the first eligible cycle SHALL arbitrate from requester 0.

Verification
REQ-033 Reset, then hold req_valid=4'b1111 with all req_up=1 for 8 cycles -> grants 0,1,2,3,0,1,2,3; every counter = 2.
REQ-034 SAT=0: load counter 1 with 8'hFF, then increment it once -> done_val=8'h00, sat_hit=0; load 8'h00, then decrement -> 8'hFF.
REQ-035 SAT=1: the same two sequences as REQ-034 -> 8'hFF and 8'h00 respectively, with sat_hit=1 on each.
REQ-036 rr_ptr=2, load_valid=1 with load_idx=2 and load_val=8'h55, req_valid=4'b0100 -> no grant; counter2=8'h55; next cycle requester 2 is granted and done_val=8'h56.
REQ-037 pause=1 for 3 cycles with all requesting -> req_ready=0 and no done pulses; after pause falls, grants resume at the held rr_ptr.
REQ-038 Requester 3 alone, back-to-back decrements from 8'h03 for 3 cycles -> done_val 8'h02, 8'h01, 8'h00 on consecutive cycles.
